wb_stage: RTL

- Writeback stage between the EXWB pipeline buffer and the RegisterFile write port.
- Buffers completed EXE results in a small in-order write queue and drains one register write per cycle when the register file accepts it.
- Gives Decode forwarding of still-pending results.
- Accumulates sticky exception flags.

---
 rtl/wb_stage.sv | 114 +++++++++++
 1 files changed

// File: rtl/wb_stage.sv
// Writeback stage: an in-order write queue between EXWB and the RegisterFile
// write port. It also forwards pending results to Decode and keeps sticky exception flags.
module wb_stage #(
  parameter int DSIZE = 32,
  parameter int ASIZE = 5,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [ASIZE-1:0]         in_addr,
  input  logic [DSIZE-1:0]         in_data,
  input  logic [3:0]               in_flags,
  output logic                     rf_we,
  output logic [ASIZE-1:0]         rf_waddr,
  output logic [DSIZE-1:0]         rf_wdata,
  input  logic                     rf_wready,
  input  logic [ASIZE-1:0]         fwd_addr_l,
  input  logic [ASIZE-1:0]         fwd_addr_r,
  output logic                     fwd_hit_l,
  output logic [DSIZE-1:0]         fwd_data_l,
  output logic                     fwd_hit_r,
  output logic [DSIZE-1:0]         fwd_data_r,
  input  logic                     clear_flags,
  output logic [3:0]               sticky_flags,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [ASIZE-1:0] addr_q [DEPTH];
  logic [DSIZE-1:0] data_q [DEPTH];
  logic [DEPTH-1:0] valid_q, valid_d;
  logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic [3:0]       sticky_q, sticky_d;
  logic             push, pop;
  logic [PW-1:0]    idx;

  assign in_ready     = (count_q != CW'(DEPTH));
  assign push         = in_valid && in_ready;
  assign rf_we        = valid_q[rd_ptr_q];
  assign rf_waddr     = addr_q[rd_ptr_q];
  assign rf_wdata     = data_q[rd_ptr_q];
  assign pop          = rf_we && rf_wready;
  assign count        = count_q;
  assign sticky_flags = sticky_q;

  always_comb begin
    valid_d  = valid_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    sticky_d = sticky_q;
    if (pop) begin
      valid_d[rd_ptr_q] = 1'b0;
      rd_ptr_d          = rd_ptr_q + PW'(1);
    end
    if (push) begin
      valid_d[wr_ptr_q] = 1'b1;
      wr_ptr_d          = wr_ptr_q + PW'(1);
    end
    count_d = count_q + CW'(push) - CW'(pop);
    // Clear takes effect before the same-cycle accumulate.
    if (clear_flags) sticky_d = '0;
    if (push)        sticky_d = sticky_d | in_flags;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      valid_q  <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      sticky_q <= '0;
    end else begin
      valid_q  <= valid_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      sticky_q <= sticky_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      addr_q[wr_ptr_q] <= in_addr;
      data_q[wr_ptr_q] <= in_data;
    end
  end

  // Scan oldest to youngest so a later match overrides an earlier one.
  always_comb begin
    fwd_hit_l  = 1'b0;
    fwd_data_l = '0;
    fwd_hit_r  = 1'b0;
    fwd_data_r = '0;
    idx        = '0;
    for (int unsigned k = 0; k < DEPTH; k++) begin
      idx = rd_ptr_q + PW'(k);
      if (valid_q[idx] && (addr_q[idx] == fwd_addr_l)) begin
        fwd_hit_l  = 1'b1;
        fwd_data_l = data_q[idx];
      end
      if (valid_q[idx] && (addr_q[idx] == fwd_addr_r)) begin
        fwd_hit_r  = 1'b1;
        fwd_data_r = data_q[idx];
      end
    end
  end

endmodule
